// File: rtl/calc_alu_arbiter_if.sv
// calc_alu_arbiter_if: request/response handshakes and ALU port bundle shared by
// the two requesters, the arbiter and the ALU.
interface calc_alu_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int RES_W  = 8
);
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic              rsp0_valid, rsp0_ready, rsp0_err;
  logic              rsp1_valid, rsp1_ready, rsp1_err;
  logic [RES_W-1:0]  rsp0_result, rsp1_result;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_start;
  logic [RES_W-1:0]  alu_result;
  logic              busy;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_err, alu_a, alu_b, alu_op, alu_start, busy
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_err, alu_a, alu_b, alu_op, alu_start, busy
  );
endinterface

// File: rtl/calc_alu_arbiter.sv
// calc_alu_arbiter: round-robin sharing of one ALU between two requesters.
// Define CALC_ARB_OPCHECK_EN to reject opcode all-ones without issuing it to the ALU.
module calc_alu_arbiter #(
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3,
  parameter int RES_W   = 8,
  parameter int ALU_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  calc_alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e            state_q, state_d;
  logic              prio_q, prio_d, win_q, win_d, err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sel_a, sel_b;
  logic [OP_W-1:0]   op_q, op_d, sel_op;
  logic [RES_W-1:0]  res_q, res_d;
  logic              idle, resp, gnt0, gnt1, accept, rsp_hs, bad_op;
  assign idle   = state_q == IDLE;
  assign resp   = state_q == RESP;
  assign gnt0   = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign gnt1   = bus.req1_valid & (~bus.req0_valid | prio_q);
  assign accept = idle & (gnt0 | gnt1);
  assign sel_a  = gnt1 ? bus.req1_a : bus.req0_a;
  assign sel_b  = gnt1 ? bus.req1_b : bus.req0_b;
  assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;
  assign rsp_hs = resp & (win_q ? bus.rsp1_ready : bus.rsp0_ready);
`ifdef CALC_ARB_OPCHECK_EN
  assign bad_op = &sel_op;
`else
  assign bad_op = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    win_d   = win_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (accept) begin
        win_d   = gnt1;
        err_d   = bad_op;
        state_d = bad_op ? RESP : ISSUE;
        res_d   = bad_op ? '0 : res_q;
        a_d     = bad_op ? a_q : sel_a;
        b_d     = bad_op ? b_q : sel_b;
        op_d    = bad_op ? op_q : sel_op;
      end
      ISSUE: begin
        state_d = (ALU_LAT == 0) ? RESP : WAIT;
        cnt_d   = 4'(ALU_LAT);
        res_d   = (ALU_LAT == 0) ? bus.alu_result : res_q;
      end
      // capture on the edge where the loaded latency count runs out
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? RESP : WAIT;
        res_d   = (cnt_q == 4'd1) ? bus.alu_result : res_q;
      end
      RESP: if (rsp_hs) begin
        state_d = IDLE;
        prio_d  = ~win_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      win_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      win_q   <= win_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end
  assign bus.req0_ready  = idle & gnt0;
  assign bus.req1_ready  = idle & gnt1;
  assign bus.rsp0_valid  = resp & ~win_q;
  assign bus.rsp1_valid  = resp & win_q;
  assign bus.rsp0_result = res_q;
  assign bus.rsp1_result = res_q;
  assign bus.rsp0_err    = resp & ~win_q & err_q;
  assign bus.rsp1_err    = resp & win_q & err_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_start   = state_q == ISSUE;
  assign bus.busy        = ~idle;
endmodule

// File: tb/tb_calc_alu_arbiter.sv
// tb_calc_alu_arbiter: scoreboard bench for calc_alu_arbiter with a latency-accurate ALU stub.
module tb_calc_alu_arbiter;
  localparam int LAT = 1;
`ifdef CALC_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif
  typedef struct {bit id; logic [3:0] a, b; logic [2:0] op; logic [7:0] res; bit err; int t;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0, since = 99;
  exp_t sbq[$];
  logic [1:0] vprev = 2'b00;
  logic [7:0] rprev = 8'h00;
  logic sprev = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  calc_alu_arbiter_if #(.DATA_W(4), .OP_W(3), .RES_W(8)) bus();
  calc_alu_arbiter #(.DATA_W(4), .OP_W(3), .RES_W(8), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (op == 3'b110) ? ({4'b0, a} * {4'b0, b}) : {op, s};
  endfunction
  function automatic exp_t mk(bit id, logic [3:0] a, logic [3:0] b, logic [2:0] op, int t);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.op = op; e.t = t;
    e.err = OPCHK && (op == 3'b111);
    e.res = e.err ? 8'h00 : alu_f(a, b, op);
    return e;
  endfunction
  // the stub only presents a real result in the cycle the arbiter must sample it
  always @(posedge clk or negedge rst_n)
    if (!rst_n) since <= 99;
    else since <= bus.alu_start ? 1 : (since < 99 ? since + 1 : 99);
  always_comb begin
    bus.alu_result = 8'hEE;
    if ((LAT == 0) ? bus.alu_start : (since == LAT && !bus.alu_start))
      bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      vprev <= 2'b00;
      sprev <= 1'b0;
    end else begin
      logic [1:0] rv;
      logic [7:0] cur;
      rv  = {bus.rsp1_valid, bus.rsp0_valid};
      cur = bus.rsp1_valid ? bus.rsp1_result : bus.rsp0_result;
      check("rdy_excl", bus.req0_ready & bus.req1_ready, 0);
      check("rdy_busy", (bus.req0_ready | bus.req1_ready) & bus.busy, 0);
      check("rsp_excl", bus.rsp0_valid & bus.rsp1_valid, 0);
      if (bus.req0_valid && bus.req0_ready) sbq.push_back(mk(1'b0, bus.req0_a, bus.req0_b, bus.req0_op, cyc));
      if (bus.req1_valid && bus.req1_ready) sbq.push_back(mk(1'b1, bus.req1_a, bus.req1_b, bus.req1_op, cyc));
      if (bus.alu_start) begin
        check("start_pulse", sprev, 0);
        if (sbq.size() == 0) check("sb_empty_start", 0, 1);
        else check("alu_ops", {bus.alu_a, bus.alu_b, bus.alu_op}, {sbq[0].a, sbq[0].b, sbq[0].op});
      end
      if (|rv) begin
        if (sbq.size() == 0) check("sb_empty_rsp", 0, 1);
        else begin
          if (vprev == 2'b00) begin
            check("rsp_id", bus.rsp1_valid, sbq[0].id);
            check("rsp_lat", cyc - sbq[0].t, sbq[0].err ? 1 : 2 + LAT);
          end else check("rsp_hold", cur, rprev);
          if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
            check("rsp_result", cur, sbq[0].res);
            check("rsp_err", bus.rsp1_valid ? bus.rsp1_err : bus.rsp0_err, sbq[0].err);
            void'(sbq.pop_front());
          end
        end
      end
      vprev <= rv;
      rprev <= cur;
      sprev <= bus.alu_start;
    end
  end
  task automatic drive(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; end
    else begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; end
  endtask
  task automatic grant(input bit id);
    int n = 0;
    logic [1:0] g;
    #1;
    while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    g = {bus.req1_ready, bus.req0_ready};
    check("grant_id", g, id ? 2'b10 : 2'b01);
    @(posedge clk);
    #1;
    if (g[0]) bus.req0_valid = 1'b0;
    if (g[1]) bus.req1_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 60);
    check("idle_timeout", bus.busy, 0);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                       bus.rsp0_err, bus.rsp1_err, bus.busy, bus.alu_start}, 0);
    check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    check("rst_res", {bus.rsp0_result, bus.rsp1_result}, 0);
    step(); rst_n = 1'b1;
    // single request, exact cycle timing
    step(); drive(0, 4'd5, 4'd5, 3'b110);
    grant(0);
    @(negedge clk);
    check("t1_start", bus.alu_start, 1);
    check("t1_ops", {bus.alu_a, bus.alu_b, bus.alu_op}, {4'd5, 4'd5, 3'b110});
    repeat (LAT) @(negedge clk);
    check("t1_rsp_early", bus.rsp0_valid, 0);
    @(negedge clk);
    check("t1_rsp", bus.rsp0_valid, 1);
    check("t1_res", bus.rsp0_result, 8'h19);
    wait_idle();
    check("t1_ops_kept", {bus.alu_a, bus.alu_b, bus.alu_op}, {4'd5, 4'd5, 3'b110});
    // prio is now 1: req1 wins the pair
    step(); drive(0, 4'hF, 4'h8, 3'b010); drive(1, 4'd3, 4'd4, 3'b001);
    grant(1);
    wait_idle();
    grant(0);
    wait_idle();
    // response backpressure while req0 waits
    step(); bus.rsp1_ready = 0; drive(1, 4'd2, 4'd7, 3'b110);
    grant(1);
    drive(0, 4'd1, 4'd1, 3'b000);
    n = 0;
    while (!bus.rsp1_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", bus.rsp1_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_rdy0", bus.req0_ready, 0);
      check("bp_busy", bus.busy, 1);
      check("bp_res", bus.rsp1_result, 8'h0E);
    end
    step(); bus.rsp1_ready = 1;
    @(negedge clk);
    check("bp_rdy0_resp", bus.req0_ready, 0);
    @(negedge clk);
    check("bp_next", bus.req0_ready, 1);
    grant(0);
    wait_idle();
    // reset in the middle of WAIT
    step(); drive(0, 4'd9, 4'd9, 3'b011);
    grant(0);
    step();
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_ctrl", {bus.busy, bus.alu_start, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready}, 0);
    check("mid_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    check("mid_res", bus.rsp0_result, 0);
    repeat (2) @(negedge clk);
    step(); rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("mid_no_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 0);
    end
    step(); drive(1, 4'd6, 4'd3, 3'b101);
    grant(1);
    wait_idle();
    // contention straight after reset alternates starting with req0
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    step(); drive(0, 4'd4, 4'd3, 3'b001); drive(1, 4'd7, 4'd7, 3'b110);
    grant(0);
    wait_idle();
    grant(1);
    wait_idle();
    step(); drive(0, 4'd4, 4'd6, 3'b010); drive(1, 4'd1, 4'd2, 3'b100);
    grant(0);
    wait_idle();
    grant(1);
    wait_idle();
    // opcode all-ones
    step(); drive(0, 4'd3, 4'd2, 3'b111);
    grant(0);
    @(negedge clk);
    check("op7_start", bus.alu_start, OPCHK ? 0 : 1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
